// File: rtl/gmii_udp_rx.sv
// GMII receive deframer for Ethernet/IPv4/UDP. Filters on local MAC/IP/port,
// streams the UDP payload and reports a per-frame good/bad status from the FCS.
module gmii_udp_rx #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
    parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        e_rxdv,
    input  logic        e_rxer,
    input  logic [7:0]  e_rxd,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] ok_cnt
);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        TAIL
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [31:0] r_crc;
    logic        r_err;
    logic        r_done;
    logic        r_mac_uc;
    logic        r_mac_bc;
    logic [15:0] r_udp_len;
    logic [15:0] r_remain;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_sop;
    logic        r_eop;
    logic        r_ok;
    logic        r_bad;
    logic [15:0] r_ok_cnt;

    logic        w_uc_ok;
    logic        w_bc_ok;
    logic        w_hdr_bad;
    logic        w_in_frame;
    logic        w_sfd;
    logic        w_pay_byte;
    logic        w_frame_end;
    logic        w_frame_good;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [5:0] idx);
        logic [7:0] b;
        case (idx)
            6'd0:    b = LOCAL_MAC[47:40];
            6'd1:    b = LOCAL_MAC[39:32];
            6'd2:    b = LOCAL_MAC[31:24];
            6'd3:    b = LOCAL_MAC[23:16];
            6'd4:    b = LOCAL_MAC[15:8];
            6'd5:    b = LOCAL_MAC[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_in_frame = (r_state == ETH_HDR) || (r_state == IP_HDR) || (r_state == UDP_HDR) ||
                        (r_state == PAYLOAD) || (r_state == TAIL);
    assign w_sfd      = (r_state == PREAMBLE) && e_rxdv && (e_rxd == 8'hD5);
    assign w_pay_byte = (r_state == PAYLOAD) && e_rxdv;
    assign w_frame_end  = ((r_state == PAYLOAD) || (r_state == TAIL)) && !e_rxdv;
    assign w_frame_good = (r_crc == CRC_RESIDUE) && !r_err && r_done;

    // Destination MAC must match unicast or broadcast across all six bytes, not a mix.
    always_comb begin
        w_uc_ok   = 1'b0;
        w_bc_ok   = 1'b0;
        w_hdr_bad = 1'b0;
        case (r_state)
            ETH_HDR: begin
                w_uc_ok = ((r_cnt == 6'd0) || r_mac_uc) && (e_rxd == mac_byte(r_cnt));
                w_bc_ok = ((r_cnt == 6'd0) || r_mac_bc) && (e_rxd == 8'hFF);
                if (r_cnt < 6'd6)
                    w_hdr_bad = !w_uc_ok && !w_bc_ok;
                else if (r_cnt == 6'd12)
                    w_hdr_bad = (e_rxd != 8'h08);
                else if (r_cnt == 6'd13)
                    w_hdr_bad = (e_rxd != 8'h00);
            end
            IP_HDR: begin
                case (r_cnt)
                    6'd0:    w_hdr_bad = (e_rxd != 8'h45);
                    6'd9:    w_hdr_bad = (e_rxd != 8'h11);
                    6'd16:   w_hdr_bad = (e_rxd != LOCAL_IP[31:24]);
                    6'd17:   w_hdr_bad = (e_rxd != LOCAL_IP[23:16]);
                    6'd18:   w_hdr_bad = (e_rxd != LOCAL_IP[15:8]);
                    6'd19:   w_hdr_bad = (e_rxd != LOCAL_IP[7:0]);
                    default: w_hdr_bad = 1'b0;
                endcase
            end
            UDP_HDR: begin
                case (r_cnt)
                    6'd2:    w_hdr_bad = (e_rxd != LOCAL_PORT[15:8]);
                    6'd3:    w_hdr_bad = (e_rxd != LOCAL_PORT[7:0]);
                    default: w_hdr_bad = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_IDLE: begin
                if (!e_rxdv) w_next = IDLE;
            end
            IDLE: begin
                if (e_rxdv) w_next = (e_rxd == 8'h55) ? PREAMBLE : WAIT_IDLE;
            end
            PREAMBLE: begin
                if (!e_rxdv)               w_next = IDLE;
                else if (e_rxd == 8'hD5)   w_next = ETH_HDR;
                else if (e_rxd != 8'h55)   w_next = WAIT_IDLE;
            end
            ETH_HDR: begin
                if (!e_rxdv)               w_next = IDLE;
                else if (w_hdr_bad)        w_next = WAIT_IDLE;
                else if (r_cnt == 6'd13)   w_next = IP_HDR;
            end
            IP_HDR: begin
                if (!e_rxdv)               w_next = IDLE;
                else if (w_hdr_bad)        w_next = WAIT_IDLE;
                else if (r_cnt == 6'd19)   w_next = UDP_HDR;
            end
            UDP_HDR: begin
                if (!e_rxdv)               w_next = IDLE;
                else if (w_hdr_bad)        w_next = WAIT_IDLE;
                else if (r_cnt == 6'd7) begin
                    if (r_udp_len < 16'd8)       w_next = WAIT_IDLE;
                    else if (r_udp_len == 16'd8) w_next = TAIL;
                    else                         w_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (!e_rxdv)                 w_next = IDLE;
                else if (r_remain == 16'd1)  w_next = TAIL;
            end
            TAIL: begin
                if (!e_rxdv) w_next = IDLE;
            end
            default: w_next = WAIT_IDLE;
        endcase
    end

    // Control state, frame flags and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT_IDLE;
            r_cnt    <= 6'd0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_ok     <= 1'b0;
            r_bad    <= 1'b0;
            r_ok_cnt <= 16'h0000;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_cnt <= 6'd0;
            else if (e_rxdv && (r_cnt != 6'h3F))
                r_cnt <= r_cnt + 6'd1;

            if (w_sfd)
                r_err <= 1'b0;
            else if (w_in_frame && e_rxdv && e_rxer)
                r_err <= 1'b1;

            if (w_sfd)
                r_done <= 1'b0;
            else if ((w_next == TAIL) && ((r_state == UDP_HDR) || (r_state == PAYLOAD)))
                r_done <= 1'b1;

            r_valid <= w_pay_byte;
            r_sop   <= w_pay_byte && (r_cnt == 6'd0);
            r_eop   <= w_pay_byte && (r_remain == 16'd1);
            if (w_pay_byte)
                r_data <= e_rxd;

            r_ok  <= w_frame_end && w_frame_good;
            r_bad <= w_frame_end && !w_frame_good;
            if (w_frame_end && w_frame_good)
                r_ok_cnt <= r_ok_cnt + 16'd1;
        end
    end

    // Datapath registers: always loaded before they are consulted, so no reset.
    always_ff @(posedge clk) begin
        if (w_sfd)
            r_crc <= 32'hFFFFFFFF;
        else if (w_in_frame && e_rxdv)
            r_crc <= crc32_byte(r_crc, e_rxd);

        if ((r_state == ETH_HDR) && e_rxdv && (r_cnt < 6'd6)) begin
            r_mac_uc <= w_uc_ok;
            r_mac_bc <= w_bc_ok;
        end

        if ((r_state == UDP_HDR) && e_rxdv) begin
            if (r_cnt == 6'd4) r_udp_len[15:8] <= e_rxd;
            if (r_cnt == 6'd5) r_udp_len[7:0]  <= e_rxd;
        end

        if ((r_state == UDP_HDR) && (w_next == PAYLOAD))
            r_remain <= r_udp_len - 16'd8;
        else if (w_pay_byte)
            r_remain <= r_remain - 16'd1;
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sop   = r_sop;
    assign out_eop   = r_eop;
    assign frame_ok  = r_ok;
    assign frame_err = r_bad;
    assign ok_cnt    = r_ok_cnt;

endmodule

// File: tb/tb_gmii_udp_rx.sv
// Directed bench for gmii_udp_rx: builds frames with a generated FCS and
// compares payload stream, status pulses and ok_cnt against hand-derived values.
module tb_gmii_udp_rx;

    localparam logic [47:0] MAC   = 48'h000A3501FEC0;
    localparam logic [15:0] PORT  = 16'h1F90;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        e_rxdv;
    logic        e_rxer;
    logic [7:0]  e_rxd;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] ok_cnt;

    always #4 clk = ~clk;

    gmii_udp_rx dut (
        .clk       (clk),
        .rst       (rst),
        .e_rxdv    (e_rxdv),
        .e_rxer    (e_rxer),
        .e_rxd     (e_rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .ok_cnt    (ok_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: payload bytes must equal the byte on e_rxd one cycle earlier.
    logic [7:0] m_data[$];
    logic       m_sop[$];
    logic       m_eop[$];
    int         m_ok = 0;
    int         m_bad = 0;
    logic [7:0] prev_rxd = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                check("latency", 32'(out_data), 32'(prev_rxd));
                m_data.push_back(out_data);
                m_sop.push_back(out_sop);
                m_eop.push_back(out_eop);
            end
            if (frame_ok === 1'b1)  m_ok++;
            if (frame_err === 1'b1) m_bad++;
            prev_rxd = e_rxd;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic clear_mon();
        m_data.delete();
        m_sop.delete();
        m_eop.delete();
        m_ok  = 0;
        m_bad = 0;
    endtask

    logic [7:0] q[$];

    task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [15:0] port,
                         input logic [15:0] ulen, input int np, input logic [7:0] pb);
        logic [15:0] tl;
        tl = ulen + 16'd20;
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(mac[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) q.push_back(8'(i * 17));
        q.push_back(et[15:8]);  q.push_back(et[7:0]);
        q.push_back(8'h45); q.push_back(8'h00); q.push_back(tl[15:8]); q.push_back(tl[7:0]);
        q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h40); q.push_back(8'h00);
        q.push_back(8'h40); q.push_back(8'h11); q.push_back(8'h00); q.push_back(8'h00);
        q.push_back(8'hC0); q.push_back(8'hA8); q.push_back(8'h00); q.push_back(8'h01);
        q.push_back(8'hC0); q.push_back(8'hA8); q.push_back(8'h00); q.push_back(8'h02);
        q.push_back(8'h04); q.push_back(8'hD2); q.push_back(port[15:8]); q.push_back(port[7:0]);
        q.push_back(ulen[15:8]); q.push_back(ulen[7:0]); q.push_back(8'h00); q.push_back(8'h00);
        for (int i = 0; i < np; i++) q.push_back(pb + 8'(i));
        while (q.size() < 60) q.push_back(8'h00);
    endtask

    // Appends the standard Ethernet FCS, then drives preamble, SFD and frame bytes.
    task automatic send(input logic [7:0] fcs_x, input int trunc, input int rxer_at, input int rst_at);
        logic [31:0] crc;
        logic [7:0]  b;
        int          n;
        crc = 32'hFFFFFFFF;
        foreach (q[i]) begin
            b = q[i];
            for (int k = 0; k < 8; k++)
                crc = (crc[0] ^ b[k]) ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        crc = ~crc;
        q.push_back(crc[7:0]);
        q.push_back(crc[15:8]);
        q.push_back(crc[23:16]);
        q.push_back(crc[31:24] ^ fcs_x);
        n = (trunc >= 0) ? trunc : q.size();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            e_rxdv = 1'b1;
            e_rxd  = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            e_rxd  = q[i];
            e_rxer = (i == rxer_at);
            if (rst_at >= 0) begin
                if (i == rst_at) rst = 1'b1;
                if (i == rst_at + 2) begin
                    rst = 1'b0;
                    clear_mon();
                end
                if (i == rst_at + 1) begin
                    @(negedge clk);
                    check("rst_mid_outs", {21'd0, out_data, out_valid, out_sop, out_eop},
                          32'd0);
                    check("rst_mid_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
                    check("rst_mid_cnt", 32'(ok_cnt), 32'd0);
                end
            end
        end
        @(posedge clk); #1;
        e_rxdv = 1'b0;
        e_rxer = 1'b0;
        e_rxd  = 8'h00;
        repeat (12) @(posedge clk);
    endtask

    task automatic chk_frame(input string tag, input int nb, input logic [7:0] base,
                             input logic eop_exp, input int ok, input int bad,
                             input logic [15:0] cnt);
        check({tag, "_nbytes"}, 32'(m_data.size()), 32'(nb));
        for (int i = 0; i < m_data.size() && i < nb; i++) begin
            check({tag, "_data"}, 32'(m_data[i]), 32'(base + 8'(i)));
            check({tag, "_sop"},  32'(m_sop[i]),  32'(i == 0));
            check({tag, "_eop"},  32'(m_eop[i]),  32'(eop_exp && (i == nb - 1)));
        end
        check({tag, "_ok"},  32'(m_ok),  32'(ok));
        check({tag, "_err"}, 32'(m_bad), 32'(bad));
        check({tag, "_cnt"}, 32'(ok_cnt), 32'(cnt));
    endtask

    initial begin
        rst    = 1'b1;
        e_rxdv = 1'b0;
        e_rxer = 1'b0;
        e_rxd  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {21'd0, out_data, out_valid, out_sop, out_eop}, 32'd0);
        check("reset_pulse", {30'd0, frame_ok, frame_err}, 32'd0);
        check("reset_cnt", 32'(ok_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h01); send(8'h00, -1, -1, -1);
        chk_frame("good", 4, 8'h01, 1'b1, 1, 0, 16'd1);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h01); send(8'h01, -1, -1, -1);
        chk_frame("bad_fcs", 4, 8'h01, 1'b1, 0, 1, 16'd1);

        clear_mon(); build(MAC, 16'h0800, 16'h1F91, 16'h000C, 4, 8'h01); send(8'h00, -1, -1, -1);
        chk_frame("flt_port", 0, 8'h00, 1'b0, 0, 0, 16'd1);

        clear_mon(); build(48'h000A3501FEC1, 16'h0800, PORT, 16'h000C, 4, 8'h01);
        send(8'h00, -1, -1, -1);
        chk_frame("flt_mac", 0, 8'h00, 1'b0, 0, 0, 16'd1);

        clear_mon(); build(MAC, 16'h0806, PORT, 16'h000C, 4, 8'h01); send(8'h00, -1, -1, -1);
        chk_frame("flt_etype", 0, 8'h00, 1'b0, 0, 0, 16'd1);

        clear_mon(); build(BCAST, 16'h0800, PORT, 16'h000C, 4, 8'h11); send(8'h00, -1, -1, -1);
        chk_frame("bcast", 4, 8'h11, 1'b1, 1, 0, 16'd2);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h0009, 1, 8'hAA); send(8'h00, -1, -1, -1);
        chk_frame("len9", 1, 8'hAA, 1'b1, 1, 0, 16'd3);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h0008, 0, 8'h00); send(8'h00, -1, -1, -1);
        chk_frame("len8", 0, 8'h00, 1'b0, 1, 0, 16'd4);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h0007, 0, 8'h00); send(8'h00, -1, -1, -1);
        chk_frame("len7", 0, 8'h00, 1'b0, 0, 0, 16'd4);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h21); send(8'h00, -1, 43, -1);
        chk_frame("rxer", 4, 8'h21, 1'b1, 0, 1, 16'd4);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h31); send(8'h00, 44, -1, -1);
        chk_frame("trunc", 2, 8'h31, 1'b0, 0, 1, 16'd4);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h41); send(8'h00, -1, -1, 43);
        chk_frame("rst_rest", 0, 8'h00, 1'b0, 0, 0, 16'd0);

        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h51); send(8'h00, -1, -1, -1);
        chk_frame("after_rst", 4, 8'h51, 1'b1, 1, 0, 16'd1);

        @(negedge clk);
        force dut.r_ok_cnt = 16'hFFFF;
        #1;
        release dut.r_ok_cnt;
        @(negedge clk);
        check("preload_cnt", 32'(ok_cnt), 32'h0000FFFF);
        clear_mon(); build(MAC, 16'h0800, PORT, 16'h000C, 4, 8'h61); send(8'h00, -1, -1, -1);
        chk_frame("wrap", 4, 8'h61, 1'b1, 1, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gmii_udp_rx.md
Name: gmii_udp_rx

Overview:
- GMII receive-side counterpart of the design's UDP/GMII transmit path (e_txd/e_txen/e_gtxc).
- Deframes Ethernet/IPv4/UDP packets arriving on e_rxd/e_rxdv/e_rxer.
- Filters on local MAC/IP/port and streams the UDP payload bytes to the design's command/config logic.
- Checks the FCS and reports a per-frame good/bad status when the frame ends.

Parameters:
LOCAL_MAC, 48'h000A3501FEC0, accepted destination MAC; broadcast FF:FF:FF:FF:FF:FF is also accepted
LOCAL_IP, 32'hC0A80002, accepted destination IPv4 address (192.168.0.2)
LOCAL_PORT, 16'h1F90, accepted UDP destination port (8080)

Ports:
clk  in  1  e_rxc receive clock, 125 MHz; all logic on its rising edge
rst  in  1  asynchronous, active-high reset
e_rxdv  in  1  GMII receive data valid
e_rxer  in  1  GMII receive error
e_rxd  in  8  GMII receive data
out_data  out  8  payload byte
out_valid  out  1  out_data valid this cycle
out_sop  out  1  first payload byte of frame (qualified by out_valid)
out_eop  out  1  last payload byte of frame (qualified by out_valid)
frame_ok  out  1  one-cycle pulse: accepted frame ended, FCS good, no e_rxer, payload complete
frame_err  out  1  one-cycle pulse: accepted frame ended with any of those conditions failing
ok_cnt  out  16  count of frame_ok pulses; wraps FFFF->0000

Behaviour:
- Reset:
  - All outputs are 0 and ok_cnt is 0.
  - State enters WAIT_IDLE, so a frame already in progress when reset is released is ignored.
- States: WAIT_IDLE, IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL.
- A byte counter (6 bits) indexes header bytes; it clears on every state change.
- WAIT_IDLE: go to IDLE on the first cycle with e_rxdv=0.
- IDLE: e_rxdv=1 with e_rxd=55h -> PREAMBLE. e_rxdv=1 with any other byte -> WAIT_IDLE.
- PREAMBLE:
  - 55h: stay.
  - D5h: -> ETH_HDR. CRC register is set to FFFFFFFFh; error flag and payload-complete flag are cleared.
  - Any other byte: -> WAIT_IDLE.
- ETH_HDR, 14 bytes:
  - Bytes 0-5 must equal LOCAL_MAC or the broadcast address.
  - Bytes 12-13 must equal 0800h.
  - After byte 13 -> IP_HDR.
- IP_HDR, 20 bytes:
  - Byte 0 must be 45h; IP options are not supported.
  - Byte 9 must be 11h.
  - Bytes 16-19 must equal LOCAL_IP.
  - After byte 19 -> UDP_HDR.
- UDP_HDR, 8 bytes:
  - Bytes 2-3 must equal LOCAL_PORT.
  - Bytes 4-5 are latched as udp_len (16 bits).
  - After byte 7: udp_len<8 -> WAIT_IDLE; udp_len=8 -> TAIL with payload-complete=1; otherwise -> PAYLOAD with remaining = udp_len-8.
- Any header compare mismatch -> WAIT_IDLE on that byte. No output and no status pulse for that frame.
- PAYLOAD:
  - Each byte is presented on out_data with out_valid=1 exactly 1 cycle after it appears on e_rxd (registered output).
  - out_sop is 1 on the first byte, out_eop on the byte where remaining=1. Both are 1 together when the payload length is 1.
  - After the last byte: payload-complete=1, -> TAIL.
- TAIL: consumes Ethernet padding and FCS with no output, until e_rxdv=0.
- CRC:
  - Reflected CRC-32, poly EDB88320h, init FFFFFFFFh, updated on every byte from the first byte after SFD through the final FCS byte.
  - FCS is good when the register equals DEBB20E3h at frame end.
- e_rxer=1 on any cycle with e_rxdv=1 in ETH_HDR..TAIL sets the error flag. Parsing continues.
- Frame end: e_rxdv=0 while in ETH_HDR..TAIL.
  - From UDP-complete states (PAYLOAD, TAIL): on the next cycle exactly one of frame_ok/frame_err pulses; frame_ok increments ok_cnt. State -> IDLE.
  - From ETH_HDR, IP_HDR or UDP_HDR: no pulse, -> IDLE.
- Truncation: if e_rxdv falls in PAYLOAD, no further out_valid, out_eop is never issued, and frame_err pulses. Downstream discards the bytes on frame_err.
- A back-to-back frame may start the cycle after the frame_ok/frame_err pulse. The IDLE->PREAMBLE transition is unaffected by the pulse.

Test Plan:
1. Good frame: 7x55h, D5h, dst MAC 000A3501FEC0, IPv4 to C0A80002, UDP port 1F90, udp_len=000Ch, payload 01 02 03 04, 14 pad bytes, correct FCS -> out_valid 4 cycles with data 01..04, sop on 01, eop on 04, each 1 cycle after input; one frame_ok pulse; ok_cnt=1.
2. Same frame with last FCS byte XOR 01h -> payload still streamed; frame_err pulse, no frame_ok; ok_cnt unchanged.
3. Filtering: dst port 1F91; separately dst MAC 000A3501FEC1; separately ethertype 0806h -> no out_valid, no status pulse. Broadcast MAC with correct IP/port -> accepted.
4. Edge lengths: udp_len=0009h with payload AAh -> single cycle with sop=eop=1, data AAh. udp_len=0008h -> no out_valid, frame_ok. udp_len=0007h -> dropped silently.
5. Errors: e_rxer=1 for one cycle during payload -> frame_err. e_rxdv drops after 2 of 4 payload bytes -> 2 valid bytes, no eop, frame_err.
6. Reset and counter:
   - Assert rst mid-payload, release while e_rxdv is still 1 -> outputs 0, rest of that frame ignored, next good frame accepted.
   - Preload ok_cnt to FFFFh via 65535 frames (or force) and send one good frame -> ok_cnt=0000h.
